// File: rtl/tlp_pkg.sv
// Shared types for the non-posted TLP tag scheduler.
// Holds the FSM encoding and the fmt/type field layout.
package tlp_pkg;

  localparam int FMT_W  = 3;
  localparam int TYPE_W = 5;
  localparam int TAG_W  = 10;
  localparam int CNT_W  = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [FMT_W-1:0]  fmt;
    logic [TYPE_W-1:0] typ;
  } fmt_type_t;

endpackage

// File: rtl/tlp_rr_arbiter.sv
// Round-robin pick: first requester at or above ptr,
// wrapping around; found=0 when nobody requests.
module tlp_rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  int c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = W'(c);
      end
    end
  end

endmodule

// File: rtl/tlp_tag_scheduler.sv
// Non-posted request scheduler: round-robin grant plus
// tag allocation from a busy bitmap, released by completions.
module tlp_tag_scheduler
  import tlp_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int NUM_TAGS          = 32,
  parameter bit SUPPORT_10BIT_TAG = 1'b0,
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sched_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_fmt_type,
  output logic [NUM_REQ-1:0]   req_gnt,
  output logic                 hdr_valid,
  input  logic                 hdr_ready,
  output logic [FMT_W-1:0]     hdr_fmt,
  output logic [TYPE_W-1:0]    hdr_type,
  output logic [RW-1:0]        hdr_req_idx,
  output logic [TAG_W-1:0]     hdr_tag,
  input  logic                 cpl_valid,
  input  logic [TAG_W-1:0]     cpl_tag,
  input  logic                 cpl_last,
  output logic                 cpl_err,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 pool_empty
);

  localparam int TIW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int MAX_TAGS = SUPPORT_10BIT_TAG ? 1024 : 256;

  if (NUM_TAGS < 2 || NUM_TAGS > MAX_TAGS) begin : g_bad_tags
    $error("tlp_tag_scheduler: NUM_TAGS out of range");
  end

  state_t              state_q, state_d;
  logic [RW-1:0]       ptr_q, win_idx, idx_q;
  logic                win_found;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [TIW-1:0]      free_idx, tag_q, cpl_idx;
  logic [CNT_W-1:0]    cnt_q;
  fmt_type_t           ft_q, win_ft;
  logic                cpl_err_q, cpl_in_range, cpl_hit;
  logic                start, hs, rel;

  tlp_rr_arbiter #(
    .N (NUM_REQ),
    .W (RW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    win_ft = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (RW'(i) == win_idx) win_ft = req_fmt_type[8*i +: 8];
    end
  end

  // Descending scan leaves the lowest free index.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = TIW'(i);
    end
  end

  assign pool_empty = (cnt_q == CNT_W'(NUM_TAGS));
  assign cpl_idx    = cpl_tag[TIW-1:0];

  assign cpl_in_range =
    ({1'b0, cpl_tag} < CNT_W'(NUM_TAGS)) &&
    (SUPPORT_10BIT_TAG || cpl_tag[9:8] == 2'b00);

  assign cpl_hit = cpl_in_range && busy_q[cpl_idx];
  assign rel     = cpl_valid && cpl_last && cpl_hit;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sched_en && win_found && !pool_empty) begin
          start   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hdr_ready) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The issuing tag is never busy, so set and clear cannot collide.
  always_comb begin
    busy_d = busy_q;
    if (hs)  busy_d[tag_q]   = 1'b1;
    if (rel) busy_d[cpl_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      ft_q      <= '0;
      cpl_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_q + CNT_W'(hs) - CNT_W'(rel);
      cpl_err_q <= cpl_valid && !cpl_hit;
      if (start) begin
        idx_q <= win_idx;
        tag_q <= free_idx;
        ft_q  <= win_ft;
      end
      if (hs) begin
        ptr_q <= (idx_q == RW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    req_gnt = '0;
    if (hs) req_gnt[idx_q] = 1'b1;
  end

  assign hdr_valid   = (state_q == ISSUE);
  assign hdr_fmt     = ft_q.fmt;
  assign hdr_type    = ft_q.typ;
  assign hdr_req_idx = idx_q;
  assign hdr_tag     = TAG_W'(tag_q);
  assign cpl_err     = cpl_err_q;
  assign outstanding = cnt_q;

endmodule

// File: tb/tb_tlp_tag_scheduler.sv
// Bench for tlp_tag_scheduler: two instances (32 and 4 tags)
// share stimulus and are compared to a pool/queue model.
module tb_tlp_tag_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_en;
  logic [3:0]  req_valid;
  logic [31:0] req_fmt_type;
  logic        hdr_ready;
  logic        cpl_valid;
  logic [9:0]  cpl_tag;
  logic        cpl_last;

  logic [3:0]  gnt  [2];
  logic        hv   [2];
  logic [2:0]  hf   [2];
  logic [4:0]  ht   [2];
  logic [1:0]  hi   [2];
  logic [9:0]  htag [2];
  logic        ce   [2];
  logic [10:0] outs [2];
  logic        pe   [2];

  always #5 clk = ~clk;

  tlp_tag_scheduler dut_a (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .req_valid(req_valid), .req_fmt_type(req_fmt_type),
    .req_gnt(gnt[0]), .hdr_valid(hv[0]),
    .hdr_ready(hdr_ready), .hdr_fmt(hf[0]),
    .hdr_type(ht[0]), .hdr_req_idx(hi[0]),
    .hdr_tag(htag[0]), .cpl_valid(cpl_valid),
    .cpl_tag(cpl_tag), .cpl_last(cpl_last),
    .cpl_err(ce[0]), .outstanding(outs[0]),
    .pool_empty(pe[0])
  );

  tlp_tag_scheduler #(.NUM_TAGS(4)) dut_b (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .req_valid(req_valid), .req_fmt_type(req_fmt_type),
    .req_gnt(gnt[1]), .hdr_valid(hv[1]),
    .hdr_ready(hdr_ready), .hdr_fmt(hf[1]),
    .hdr_type(ht[1]), .hdr_req_idx(hi[1]),
    .hdr_tag(htag[1]), .cpl_valid(cpl_valid),
    .cpl_tag(cpl_tag), .cpl_last(cpl_last),
    .cpl_err(ce[1]), .outstanding(outs[1]),
    .pool_empty(pe[1])
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit log_en = 1'b0;
  int cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: busy pool, pointer and one pending issue per instance.
  bit       m_busy [2][32];
  int       m_ptr  [2];
  int       m_win  [2];
  int       m_tag  [2];
  bit       m_iss  [2];
  bit       m_err  [2];
  bit [7:0] m_ft   [2];

  function automatic int nt(int k);
    return (k == 0) ? 32 : 4;
  endfunction

  function automatic int m_count(int k);
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(m_busy[k][i]);
    return s;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int n, t, w;
      bit hit, rel, fnd;
      if (!rst) begin
        for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
        m_ptr[k] = 0; m_win[k] = 0; m_tag[k] = 0;
        m_iss[k] = 0; m_err[k] = 0; m_ft[k] = '0;
      end else begin
        n = m_count(k);
        t = int'(cpl_tag);
        hit = cpl_valid && (t < nt(k)) && m_busy[k][t];
        rel = hit && cpl_last;
        if (m_iss[k]) begin
          if (hdr_ready) begin
            m_busy[k][m_tag[k]] = 1'b1;
            m_ptr[k] = (m_win[k] + 1) % 4;
            m_iss[k] = 1'b0;
          end
        end else if (sched_en && req_valid != 0 && n < nt(k)) begin
          fnd = 0; w = 0;
          for (int i = 0; i < 4; i++) begin
            if (!fnd && req_valid[(m_ptr[k] + i) % 4]) begin
              fnd = 1; w = (m_ptr[k] + i) % 4;
            end
          end
          fnd = 0;
          for (int i = 0; i < nt(k); i++) begin
            if (!fnd && !m_busy[k][i]) begin
              fnd = 1; m_tag[k] = i;
            end
          end
          m_win[k] = w;
          m_ft[k]  = req_fmt_type[8*w +: 8];
          m_iss[k] = 1'b1;
        end
        if (rel) m_busy[k][t] = 1'b0;
        m_err[k] = cpl_valid && !hit;
      end
    end
  end

  int lg_idx0[$], lg_tag0[$], lg_cyc0[$];
  int lg_idx1[$], lg_tag1[$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int eg;
        eg = (m_iss[k] && hdr_ready) ? (1 << m_win[k]) : 0;
        chk($sformatf("hdr_valid%0d", k), 32'(hv[k]), 32'(m_iss[k]));
        chk($sformatf("req_gnt%0d", k), 32'(gnt[k]), eg);
        chk($sformatf("outstanding%0d", k), 32'(outs[k]), m_count(k));
        chk($sformatf("pool_empty%0d", k), 32'(pe[k]),
            32'(m_count(k) == nt(k)));
        chk($sformatf("cpl_err%0d", k), 32'(ce[k]), 32'(m_err[k]));
        if (m_iss[k]) begin
          chk($sformatf("hdr_tag%0d", k), 32'(htag[k]), m_tag[k]);
          chk($sformatf("hdr_idx%0d", k), 32'(hi[k]), m_win[k]);
          chk($sformatf("hdr_fmt%0d", k), 32'(hf[k]), 32'(m_ft[k][7:5]));
          chk($sformatf("hdr_type%0d", k), 32'(ht[k]), 32'(m_ft[k][4:0]));
        end
      end
    end
    if (log_en) begin
      for (int j = 0; j < 4; j++) begin
        if (gnt[0][j]) begin
          lg_idx0.push_back(j);
          lg_tag0.push_back(int'(htag[0]));
          lg_cyc0.push_back(cyc);
        end
        if (gnt[1][j]) begin
          lg_idx1.push_back(j);
          lg_tag1.push_back(int'(htag[1]));
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_cpl(logic [9:0] t, logic last);
    cpl_valid = 1'b1; cpl_tag = t; cpl_last = last;
    step(1);
    cpl_valid = 1'b0; cpl_last = 1'b0;
  endtask

  int exp_i [5] = '{0, 1, 2, 3, 0};
  int o_a;

  initial begin
    rst = 1'b0; sched_en = 1'b0; req_valid = '0;
    req_fmt_type = 32'h0204_2000;
    hdr_ready = 1'b0; cpl_valid = 1'b0;
    cpl_tag = '0; cpl_last = 1'b0;
    step(2);
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_hdr_valid", 32'(hv[k]), 0);
      chk("rst_outstanding", 32'(outs[k]), 0);
      chk("rst_pool_empty", 32'(pe[k]), 0);
      chk("rst_hdr_tag", 32'(htag[k]), 0);
      chk("rst_req_gnt", 32'(gnt[k]), 0);
    end

    // Back-to-back grants; the 4-tag instance runs dry.
    rst = 1'b1; sched_en = 1'b1; req_valid = 4'hf;
    hdr_ready = 1'b1; log_en = 1'b1;
    step(10);
    sched_en = 1'b0;
    step(2);
    log_en = 1'b0;
    chk("rr_count_a", lg_idx0.size(), 5);
    for (int i = 0; i < 5 && i < lg_idx0.size(); i++) begin
      chk($sformatf("rr_idx_a%0d", i), lg_idx0[i], exp_i[i]);
      chk($sformatf("rr_tag_a%0d", i), lg_tag0[i], i);
      if (i > 0)
        chk($sformatf("rr_gap_a%0d", i), lg_cyc0[i] - lg_cyc0[i-1], 2);
    end
    chk("dry_count_b", lg_idx1.size(), 4);
    for (int i = 0; i < 4 && i < lg_tag1.size(); i++)
      chk($sformatf("dry_tag_b%0d", i), lg_tag1[i], i);
    chk("dry_out_a", 32'(outs[0]), 5);
    chk("dry_out_b", 32'(outs[1]), 4);
    chk("dry_empty_b", 32'(pe[1]), 1);
    chk("dry_hv_b", 32'(hv[1]), 0);

    // Stall in ISSUE; request and enable drop meanwhile.
    hdr_ready = 1'b0; sched_en = 1'b1; req_valid = 4'b0010;
    step(1);
    req_valid = '0; sched_en = 1'b0;
    chk("stall_idx", 32'(hi[0]), 1);
    chk("stall_tag", 32'(htag[0]), 5);
    chk("stall_fmt", 32'(hf[0]), 1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_hv", 32'(hv[0]), 1);
      chk("stall_tag_hold", 32'(htag[0]), 5);
      chk("stall_idx_hold", 32'(hi[0]), 1);
      chk("stall_gnt", 32'(gnt[0]), 0);
    end
    hdr_ready = 1'b1;
    #1;
    chk("stall_gnt_rdy", 32'(gnt[0]), 32'h2);
    step(1);
    chk("stall_out", 32'(outs[0]), 6);

    // Completions to free / out-of-range tags.
    pulse_cpl(10'd7, 1'b1);
    chk("err7_a", 32'(ce[0]), 1);
    chk("err7_b", 32'(ce[1]), 1);
    chk("err7_out_a", 32'(outs[0]), 6);
    step(1);
    chk("err7_clear", 32'(ce[0]), 0);
    pulse_cpl(10'h100, 1'b1);
    chk("err100_a", 32'(ce[0]), 1);
    chk("err100_out", 32'(outs[0]), 6);
    pulse_cpl(10'd1, 1'b0);
    chk("nolast_err", 32'(ce[0]), 0);
    chk("nolast_out", 32'(outs[0]), 6);

    // Release of tag 2 makes it the next allocation.
    pulse_cpl(10'd2, 1'b1);
    chk("rel2_out_b", 32'(outs[1]), 3);
    chk("rel2_empty_b", 32'(pe[1]), 0);
    sched_en = 1'b1; req_valid = 4'b0001;
    step(1);
    sched_en = 1'b0;
    chk("rel2_tag_b", 32'(htag[1]), 2);
    chk("rel2_tag_a", 32'(htag[0]), 2);
    step(1);

    // Handshake and release in the same cycle.
    hdr_ready = 1'b0; sched_en = 1'b1; req_valid = 4'b0100;
    step(1);
    sched_en = 1'b0;
    chk("same_issue_tag", 32'(htag[0]), 6);
    o_a = int'(outs[0]);
    hdr_ready = 1'b1;
    pulse_cpl(10'd0, 1'b1);
    chk("same_out_a", 32'(outs[0]), o_a);
    chk("same_out_b", 32'(outs[1]), 3);
    sched_en = 1'b1; req_valid = 4'b0001;
    step(1);
    sched_en = 1'b0;
    chk("same_tag0_a", 32'(htag[0]), 0);
    chk("same_tag0_b", 32'(htag[1]), 0);
    step(1);
    chk("same_out7_a", 32'(outs[0]), 7);
    pulse_cpl(10'd6, 1'b0);
    chk("same_busy6", 32'(ce[0]), 0);

    // Reset while an issue is pending.
    hdr_ready = 1'b0; sched_en = 1'b1; req_valid = 4'b1000;
    step(1);
    chk("rst_pend_hv", 32'(hv[0]), 1);
    rst = 1'b0; sched_en = 1'b0;
    step(1);
    chk("rst_iss_hv", 32'(hv[0]), 0);
    chk("rst_iss_gnt", 32'(gnt[0]), 0);
    chk("rst_iss_out", 32'(outs[0]), 0);
    rst = 1'b1; sched_en = 1'b1; req_valid = 4'hf;
    hdr_ready = 1'b1;
    step(1);
    sched_en = 1'b0;
    chk("post_rst_idx", 32'(hi[0]), 0);
    chk("post_rst_tag", 32'(htag[0]), 0);
    chk("post_rst_gnt", 32'(gnt[0]), 1);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
